// File: rtl/and16_arbiter_if.sv
// Requester-side bundle for and16_arbiter: level requests, packed operand pairs, pulsed acks, shared result.
interface and16_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]      req;
   logic [16*NREQ-1:0]   a_bus;
   logic [16*NREQ-1:0]   b_bus;
   logic [NREQ-1:0]      ack;
   logic [15:0]          out;
   logic [IDW-1:0]       out_id;
   logic                 busy;

   modport master (
      output req, a_bus, b_bus,
      input  ack, out, out_id, busy
   );

   modport slave (
      input  req, a_bus, b_bus,
      output ack, out, out_id, busy
   );
endinterface

// File: rtl/and16_arbiter.sv
// Round-robin sharing of one and16 unit between NREQ requesters; ack pulses two edges after grant sampling.
module and16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);
   assign y = a & b;
endmodule

module and16_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic          clk,
   input  logic          reset,
   and16_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]      state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  gnt;
   logic [15:0]     op_a;
   logic [15:0]     op_b;
   logic [NREQ-1:0] ack_q;
   logic [15:0]     out_q;
   logic [IDW-1:0]  out_id_q;

   logic [NREQ-1:0] rot;
   logic            found;
   logic [IDW-1:0]  pick;
   logic [15:0]     sel_a;
   logic [15:0]     sel_b;
   logic [IDW-1:0]  ptr_nxt;
   logic [15:0]     and_y;

   // Rotate requests so bit 0 is the requester at ptr; first set bit wins.
   always_comb begin
      rot   = NREQ'({bus.req, bus.req} >> ptr);
      found = 1'b0;
      pick  = '0;
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            pick  = IDW'((int'(ptr) + k) % NREQ);
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         if (pick == IDW'(k)) begin
            sel_a = bus.a_bus[16*k +: 16];
            sel_b = bus.b_bus[16*k +: 16];
         end
      end
   end

   assign ptr_nxt = IDW'((int'(gnt) + 1) % NREQ);

   and16 u_and16 (
      .a (op_a),
      .b (op_b),
      .y (and_y)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         ptr      <= '0;
         gnt      <= '0;
         op_a     <= '0;
         op_b     <= '0;
         ack_q    <= '0;
         out_q    <= '0;
         out_id_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  op_a  <= sel_a;
                  op_b  <= sel_b;
                  gnt   <= pick;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               out_q    <= and_y;
               out_id_q <= gnt;
               ack_q    <= NREQ'(1) << gnt;
               ptr      <= ptr_nxt;
               state    <= S_RESP;
            end
            S_RESP: begin
               // Requests are ignored here so the acked requester can drop req cleanly.
               ack_q <= '0;
               state <= S_IDLE;
            end
            default: begin
               ack_q <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ack    = ack_q;
   assign bus.out    = out_q;
   assign bus.out_id = out_id_q;
   assign bus.busy   = (state != S_IDLE);
endmodule

// File: tb/tb_and16_arbiter.sv
// Directed bench for and16_arbiter: reset, ordering, fairness, withdrawal, mid-op reset, operand isolation.
module tb_and16_arbiter;
   logic clk;
   logic reset;
   int   tests;
   int   fails;
   int   cyc;
   int   last;
   int   acks_seen;

   and16_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

   and16_arbiter #(.NREQ(4), .IDW(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input string tag);
      int n;
      n = 0;
      while (bus.ack == '0 && n < 12) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.ack != '0), 32'd1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cyc   = 0;
      reset = 1'b1;
      bus.req   = '0;
      bus.a_bus = '0;
      bus.b_bus = '0;

      // Reset state
      tick();
      tick();
      chk("rst_ack", bus.ack, 0);
      chk("rst_out", bus.out, 0);
      chk("rst_id", bus.out_id, 0);
      chk("rst_busy", bus.busy, 0);
      reset = 1'b0;

      // Single request from requester 0
      bus.req = 4'b0001;
      bus.a_bus[15:0] = 16'hF0F0;
      bus.b_bus[15:0] = 16'hFF00;
      tick();
      chk("t1_busy", bus.busy, 1);
      chk("t1_ack_early", bus.ack, 0);
      tick();
      chk("t1_ack", bus.ack, 4'b0001);
      chk("t1_out", bus.out, 16'hF000);
      chk("t1_id", bus.out_id, 0);
      bus.req = 4'b0000;
      tick();
      chk("t1_ack_low", bus.ack, 0);
      chk("t1_idle", bus.busy, 0);
      chk("t1_ptr", dut.ptr, 1);
      chk("t1_out_hold", bus.out, 16'hF000);

      // All four at once after a fresh reset, each drops on its ack
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.a_bus = {4{16'hFFFF}};
      bus.b_bus = {16'hF000, 16'h0F00, 16'h00F0, 16'h000F};
      bus.req   = 4'b1111;
      last = 0;
      for (int i = 0; i < 4; i++) begin
         wait_ack($sformatf("t2_wait%0d", i));
         chk($sformatf("t2_ack%0d", i), bus.ack, 32'(1 << i));
         chk($sformatf("t2_out%0d", i), bus.out, 32'(16'h000F << (4 * i)));
         chk($sformatf("t2_id%0d", i), bus.out_id, i);
         if (i > 0) chk($sformatf("t2_gap%0d", i), cyc - last, 3);
         last = cyc;
         bus.req[i] = 1'b0;
         tick();
         chk($sformatf("t2_pulse%0d", i), bus.ack, 0);
      end
      chk("t2_ptr_wrap", dut.ptr, 0);

      // Persistent requesters 1 and 3 alternate
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.a_bus[31:16] = 16'h00FF;
      bus.b_bus[31:16] = 16'h0FF0;
      bus.a_bus[63:48] = 16'hFF00;
      bus.b_bus[63:48] = 16'hF0F0;
      bus.req = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         wait_ack($sformatf("t3_wait%0d", i));
         chk($sformatf("t3_id%0d", i), bus.out_id, (i % 2 == 0) ? 1 : 3);
         chk($sformatf("t3_out%0d", i), bus.out, (i % 2 == 0) ? 16'h00F0 : 16'hF000);
         tick();
      end
      bus.req = 4'b0000;
      tick();
      tick();

      // Withdraw before grant
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.req = 4'b0011;
      tick();
      chk("t4_busy", bus.busy, 1);
      bus.req = 4'b0010;
      tick();
      chk("t4_ack0", bus.ack, 4'b0001);
      chk("t4_id0", bus.out_id, 0);
      tick();
      tick();
      tick();
      chk("t4_ack1", bus.ack, 4'b0010);
      chk("t4_id1", bus.out_id, 1);
      bus.req = 4'b0100;
      tick();
      bus.req = 4'b0000;
      acks_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.ack != '0) acks_seen++;
      end
      chk("t4_no_ack", acks_seen, 0);
      chk("t4_idle", bus.busy, 0);

      // Reset while in EXEC
      bus.a_bus[15:0] = 16'hAAAA;
      bus.b_bus[15:0] = 16'hFFFF;
      bus.req = 4'b0001;
      tick();
      chk("t5_busy", bus.busy, 1);
      reset = 1'b1;
      bus.req = 4'b0000;
      tick();
      reset = 1'b0;
      chk("t5_ack", bus.ack, 0);
      chk("t5_out", bus.out, 0);
      chk("t5_id", bus.out_id, 0);
      chk("t5_busy_clr", bus.busy, 0);
      chk("t5_ptr", dut.ptr, 0);
      acks_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.ack != '0) acks_seen++;
      end
      chk("t5_no_ack", acks_seen, 0);
      bus.req = 4'b0001;
      wait_ack("t5_wait");
      chk("t5_out_new", bus.out, 16'hAAAA);
      chk("t5_id_new", bus.out_id, 0);
      bus.req = 4'b0000;
      tick();

      // Operand change after grant has no effect
      bus.a_bus[47:32] = 16'h1234;
      bus.b_bus[47:32] = 16'hFFFF;
      bus.req = 4'b0100;
      tick();
      chk("t6_busy", bus.busy, 1);
      bus.a_bus[47:32] = 16'h0000;
      wait_ack("t6_wait");
      chk("t6_out", bus.out, 16'h1234);
      chk("t6_id", bus.out_id, 2);
      chk("t6_ack", bus.ack, 4'b0100);
      bus.req = 4'b0000;
      tick();
      chk("t6_ack_low", bus.ack, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/and16_arbiter.md
Name: and16_arbiter

Overview:
- Shares one and16 datapath instance between NREQ requesters, each presenting a 16-bit operand pair.
- Round-robin arbitration with a level-request / single-pulse-acknowledge handshake.
- Operands and result are registered; one operation is in flight at a time.
- Sits between requesting blocks and the and16 bitwise unit.

Parameters:
- NREQ, 4, number of requesters (2..2**IDW).
- IDW, 2, width of the granted-requester index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  req[i] high = requester i wants an operation; held until its ack.
- a_bus  input  16*NREQ  operand A of requester i at bits [16*i+15:16*i].
- b_bus  input  16*NREQ  operand B of requester i, same packing.
- ack  output  NREQ  one-hot, one-cycle pulse: result for requester i is valid.
- out  output  16  registered result, A AND B of the granted requester.
- out_id  output  IDW  index of the requester whose result is on out.
- busy  output  1  high when state is not IDLE.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset is sampled only at the rising edge and overrides everything.
  - state=IDLE, ptr=0, ack=0, out=16'h0000, out_id=0, busy=0.
  - Operand registers are cleared.
  - Any in-flight operation is discarded with no ack.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If req != 0 at the edge: pick g = first i with req[i]=1, searching ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ).
  - Latch op_a/op_b from slice g and gnt=g, then go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - op_a/op_b feed an and16 instance. The AND must be done through that instance, not a behavioural operator.
  - At the edge: out <= and16 result, out_id <= gnt, ack <= one-hot(gnt), ptr <= (gnt+1) mod NREQ, go to RESP.
- RESP:
  - ack is high for exactly this cycle.
  - At the edge: ack <= 0, go to IDLE. out and out_id hold until the next EXEC edge.
  - req is ignored in RESP, so a requester may drop req at the edge where it sees ack.
- Latency: ack visible two edges after req is sampled in IDLE. Throughput is at most one operation per 3 cycles.
- Handshake rules:
  - A requester holds req and its operands stable until ack.
  - Operand changes after the grant edge have no effect on the result.
  - A requester that keeps req high after ack is treated as a new request and competes at the next IDLE.
  - Dropping req before it is granted withdraws the request with no ack.
- Fairness and wrap-around:
  - The last granted requester has lowest priority next time.
  - ptr wraps from NREQ-1 to 0.
  - Simultaneous requests are resolved purely by ptr.
- busy = (state != IDLE), registered-state decode.
- At most one ack bit is ever set. ack is never set outside RESP.

Test Plan:
- Single request, ptr=0: after reset, req=0001, a0=16'hF0F0, b0=16'hFF00 -> busy=1 next cycle; ack=0001, out=16'hF000, out_id=0 two edges after sampling; ack low the following cycle; ptr=1.
- All four request simultaneously; each drops req on its ack; a_i=16'hFFFF, b_i=16'h000F<<(4*i) -> acks in order 0,1,2,3, out = 16'h000F, 16'h00F0, 16'h0F00, 16'hF000; every ack is one cycle, 3 cycles apart; ptr returns to 0.
- Fairness with persistent requesters: req=1010 held high continuously from reset -> grant order 1,3,1,3,...; requester 1 never receives two consecutive grants.
- Withdraw before grant: req=0011 for one cycle, then req=0010 while requester 0 is being served -> requester 1 is served next; no ack for a requester that withdrew before grant.
- Reset mid-operation: assert reset for one edge while in EXEC (a0=16'hAAAA, b0=16'hFFFF) -> no ack ever for that op; out=0, out_id=0, busy=0, ptr=0 after the edge; a fresh req=0001 then completes normally with out=16'hAAAA.
- Operand isolation: change a_bus slice 2 the cycle after grant of requester 2 (a2=16'h1234 -> 16'h0000, b2=16'hFFFF) -> out=16'h1234.
